// File: rtl/img_disp_pkg.sv
// Shared display-path definitions: reader FSM state encoding and the default fill pixel.
package img_disp_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_VS = 2'd0,
        ST_WAIT_DE = 2'd1,
        ST_ACTIVE  = 2'd2
    } disp_state_e;

    localparam logic [7:0] FILL_PIX_DEF = 8'h00;
    localparam int         UF_CNT_W     = 16;

endpackage

// File: rtl/pixel_fifo_reader_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count, held once every bit is set
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pixel_fifo_reader.sv
// Reads one pixel per data-enable cycle from the line FIFO and re-aligns syncs with it
// (1-cycle latency), substituting a fill pixel on underflow or before the first frame.
module pixel_fifo_reader
    import img_disp_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter logic [DATA_W-1:0] FILL_PIX = DATA_W'(FILL_PIX_DEF),
    parameter int                CNT_W    = 12
) (
    input  logic                sys_clk,
    input  logic                rst,
    input  logic                vs_in,
    input  logic                hs_in,
    input  logic                de_in,
    input  logic                fifo_empty,
    input  logic [DATA_W-1:0]   fifo_dout,
    output logic                fifo_rd,
    output logic                o_next,
    output logic [DATA_W-1:0]   pix_data,
    output logic                vs_out,
    output logic                hs_out,
    output logic                de_out,
    output logic [CNT_W-1:0]    pix_cnt,
    output logic [CNT_W-1:0]    line_cnt,
    output logic                underflow,
    output logic [UF_CNT_W-1:0] underflow_cnt
);

    disp_state_e      state_q;
    logic             vs_q, hs_q, de_q;
    logic             vs_d2_q, de_d2_q;
    logic             rd_q, o_next_q, underflow_q;
    logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
    logic             streaming_s, vs_rise_s, de_fall_s, uf_s, next_s;

    // Input edge detection, read/underflow qualification and loader request
    always_comb begin
        streaming_s = (state_q != ST_WAIT_VS);
        vs_rise_s   = vs_in & ~vs_q;
        de_fall_s   = de_q & ~de_in;
        fifo_rd     = streaming_s & de_in & ~fifo_empty;
        uf_s        = streaming_s & de_in & fifo_empty;
        next_s      = ((state_q == ST_ACTIVE) & de_fall_s) |
                      ((state_q == ST_WAIT_VS) & vs_rise_s);
    end

    // Position counters track the delayed (output-side) timing so they match pix_data
    always_comb begin
        pix_cnt_d  = '0;
        line_cnt_d = line_cnt_q;
        if (de_q) begin
            pix_cnt_d = pix_cnt_q + CNT_W'(1);
        end else begin
            pix_cnt_d = '0;
        end
        if (vs_q && !vs_d2_q) begin
            line_cnt_d = '0;
        end else if (de_d2_q && !de_q) begin
            line_cnt_d = line_cnt_q + CNT_W'(1);
        end else begin
            line_cnt_d = line_cnt_q;
        end
    end

    // Reader FSM plus all registered outputs
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q     <= ST_WAIT_VS;
            vs_q        <= 1'b0;
            hs_q        <= 1'b0;
            de_q        <= 1'b0;
            vs_d2_q     <= 1'b0;
            de_d2_q     <= 1'b0;
            rd_q        <= 1'b0;
            o_next_q    <= 1'b0;
            pix_cnt_q   <= '0;
            line_cnt_q  <= '0;
            underflow_q <= 1'b0;
        end else begin
            vs_q       <= vs_in;
            hs_q       <= hs_in;
            de_q       <= de_in;
            vs_d2_q    <= vs_q;
            de_d2_q    <= de_q;
            rd_q       <= fifo_rd;
            o_next_q   <= next_s;
            pix_cnt_q  <= pix_cnt_d;
            line_cnt_q <= line_cnt_d;
            if (uf_s) begin
                underflow_q <= 1'b1;
            end
            case (state_q)
                ST_WAIT_VS: if (vs_rise_s) state_q <= ST_WAIT_DE;
                ST_WAIT_DE: if (de_in) state_q <= ST_ACTIVE;
                ST_ACTIVE:  if (vs_rise_s || de_fall_s) state_q <= ST_WAIT_DE;
                default:    state_q <= ST_WAIT_VS;
            endcase
        end
    end

    // FIFO data arrives one cycle after the read, so the pixel mux selects it directly
    always_comb begin
        if (rd_q) begin
            pix_data = fifo_dout;
        end else begin
            pix_data = FILL_PIX;
        end
    end

    sat_counter #(.W(UF_CNT_W)) u_uf_cnt (
        .clk_i (sys_clk),
        .rst_i (rst),
        .inc_i (uf_s),
        .cnt_o (underflow_cnt)
    );

    assign vs_out    = vs_q;
    assign hs_out    = hs_q;
    assign de_out    = de_q;
    assign o_next    = o_next_q;
    assign pix_cnt   = pix_cnt_q;
    assign line_cnt  = line_cnt_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_pixel_fifo_reader.sv
// Self-checking bench for pixel_fifo_reader: directed table, corner sequences, random frames.
module tb_pixel_fifo_reader;

    localparam logic [7:0] FILL = 8'h00;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b0, vs_in = 1'b0, hs_in = 1'b0, de_in = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [7:0]  fifo_dout = 8'h00;
    logic        fifo_rd, o_next, vs_out, hs_out, de_out, underflow;
    logic [7:0]  pix_data;
    logic [11:0] pix_cnt, line_cnt;
    logic [15:0] underflow_cnt;

    pixel_fifo_reader dut (
        .sys_clk(sys_clk), .rst(rst), .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in),
        .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_rd(fifo_rd), .o_next(o_next),
        .pix_data(pix_data), .vs_out(vs_out), .hs_out(hs_out), .de_out(de_out),
        .pix_cnt(pix_cnt), .line_cnt(line_cnt), .underflow(underflow),
        .underflow_cnt(underflow_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] fq[$];   // contents of the loader FIFO (stimulus side)
    logic [7:0] mq[$];   // reference model's view of what should come out

    // Reference model state, expressed as frame/line bookkeeping
    bit          m_known = 1'b0, m_armed = 1'b0, m_uf = 1'b0;
    logic [15:0] m_ufc = 16'd0;
    bit          m_vs_prev = 1'b0, m_de_prev = 1'b0, m_out_vs = 1'b0, m_out_de = 1'b0;
    logic [11:0] m_run = 12'd0, m_lc = 12'd0;
    logic [7:0]  e_pix = 8'h00;
    bit          e_next = 1'b0, e_vs = 1'b0, e_hs = 1'b0, e_de = 1'b0;
    bit          rd_seen = 1'b0;

    typedef struct {
        logic       vs, hs, de;
        logic       x_rd;
        logic [7:0] x_pix;
        logic       x_de, x_next;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
        mq.push_back(b);
    endtask

    task automatic clear_fifo();
        fq.delete();
        mq.delete();
    endtask

    // One clock: drive inputs, predict, clock, serve FIFO read, compare
    task automatic step(input logic r, input logic v, input logic h, input logic d,
                        input bit do_chk = 1'b1);
        logic e_rd;
        logic [11:0] e_pc, e_lc;
        rst = r; vs_in = v; hs_in = h; de_in = d;
        fifo_empty = (fq.size() == 0);
        #1;
        e_rd = m_armed && d && !fifo_empty;
        if (m_known && do_chk) chk("fifo_rd", fifo_rd, e_rd);
        rd_seen = (fifo_rd === 1'b1);
        if (e_rd && mq.size() != 0) e_pix = mq.pop_front();
        else e_pix = FILL;
        if (r) begin
            m_known = 1'b1; m_armed = 1'b0; m_uf = 1'b0; m_ufc = 16'd0;
            m_vs_prev = 1'b0; m_de_prev = 1'b0; m_out_vs = 1'b0; m_out_de = 1'b0;
            m_run = 12'd0; m_lc = 12'd0;
            e_pix = FILL; e_next = 1'b0; e_vs = 1'b0; e_hs = 1'b0; e_de = 1'b0;
        end else begin
            if (m_armed && d && fifo_empty) begin
                m_uf = 1'b1;
                if (m_ufc != 16'hFFFF) m_ufc = m_ufc + 16'd1;
            end
            e_next = (m_armed && m_de_prev && !d) || (!m_armed && v && !m_vs_prev);
            if (v && !m_vs_prev) m_armed = 1'b1;
            e_vs = v; e_hs = h; e_de = d;
            m_vs_prev = v; m_de_prev = d;
        end
        @(posedge sys_clk);
        #1;
        if (rd_seen && fq.size() != 0) fifo_dout = fq.pop_front();
        #1;
        e_pc = m_run;
        e_lc = m_lc;
        if (do_chk) begin
            chk("pix_data", pix_data, e_pix);
            chk("vs_out", vs_out, e_vs);
            chk("hs_out", hs_out, e_hs);
            chk("de_out", de_out, e_de);
            chk("o_next", o_next, e_next);
            chk("underflow", underflow, m_uf);
            chk("underflow_cnt", underflow_cnt, m_ufc);
            chk("pix_cnt", pix_cnt, e_pc);
            chk("line_cnt", line_cnt, e_lc);
        end
        m_run = e_de ? m_run + 12'd1 : 12'd0;
        if (e_vs && !m_out_vs) m_lc = 12'd0;
        else if (!e_de && m_out_de) m_lc = m_lc + 12'd1;
        m_out_vs = e_vs;
        m_out_de = e_de;
    endtask

    task automatic vs_pulse();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    vec_t vt[8];

    initial begin
        // Power-up reset: all outputs at reset values
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_pix", pix_data, FILL);
        chk("rst_ufc", underflow_cnt, 16'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // de before any vsync: no reads, fill pixels, de_out mirrors de_in
        clear_fifo();
        push(8'h55); push(8'h66); push(8'h77);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
            chk("pre_vs_rd", rd_seen, 1'b0);
            chk("pre_vs_pix", pix_data, FILL);
            chk("pre_vs_de", de_out, 1'b1);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("pre_vs_fifo_untouched", fq.size(), 3);

        // Basic 4-pixel line from a table
        vt[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
        vt[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vt[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0};
        vt[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1, 1'b0};
        vt[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h33, 1'b1, 1'b0};
        vt[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h44, 1'b1, 1'b0};
        vt[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
        vt[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        step(1'b1, 1'b0, 1'b0, 1'b0);
        clear_fifo();
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, vt[i].vs, vt[i].hs, vt[i].de);
            chk("tbl_rd", rd_seen, vt[i].x_rd);
            chk("tbl_pix", pix_data, vt[i].x_pix);
            chk("tbl_de", de_out, vt[i].x_de);
            chk("tbl_next", o_next, vt[i].x_next);
        end

        // Two entries for a four-pixel line: two fill pixels and two underflows
        step(1'b1, 1'b0, 1'b0, 1'b0);
        clear_fifo();
        push(8'h11); push(8'h22);
        vs_pulse();
        step(1'b0, 1'b0, 1'b0, 1'b1); chk("uf_pix0", pix_data, 8'h11);
        step(1'b0, 1'b0, 1'b0, 1'b1); chk("uf_pix1", pix_data, 8'h22);
        step(1'b0, 1'b0, 1'b0, 1'b1); chk("uf_pix2", pix_data, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b1); chk("uf_pix3", pix_data, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("uf_flag", underflow, 1'b1);
        chk("uf_cnt", underflow_cnt, 16'd2);

        // Three lines then vsync: line counter and per-line pixel counter
        step(1'b1, 1'b0, 1'b0, 1'b0);
        clear_fifo();
        for (int i = 0; i < 12; i++) push(8'(i + 1));
        vs_pulse();
        for (int l = 0; l < 3; l++) begin
            for (int p = 0; p < 4; p++) begin
                step(1'b0, 1'b0, 1'b0, 1'b1);
                chk("ln_line_cnt", line_cnt, 12'(l));
                chk("ln_pix_cnt", pix_cnt, 12'(p));
            end
            step(1'b0, 1'b0, 1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("ln_after3", line_cnt, 12'd3);
        vs_pulse();
        chk("ln_vs_clear", line_cnt, 12'd0);

        // Reset in the middle of a line, then no reads until the next vsync
        step(1'b1, 1'b0, 1'b0, 1'b0);
        clear_fifo();
        for (int i = 0; i < 8; i++) push(8'hA0 + 8'(i));
        vs_pulse();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("mid_rst_pix", pix_data, FILL);
        chk("mid_rst_de", de_out, 1'b0);
        chk("mid_rst_pcnt", pix_cnt, 12'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
            chk("mid_rst_no_rd", rd_seen, 1'b0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        vs_pulse();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("mid_rst_rd_resumes", rd_seen, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Random frames with random FIFO fill against the model
        step(1'b1, 1'b0, 1'b0, 1'b0);
        clear_fifo();
        for (int f = 0; f < 6; f++) begin
            if ($urandom_range(1, 0) == 1) step(1'b0, 1'b1, 1'b0, 1'b0);
            vs_pulse();
            for (int l = 0; l < int'($urandom_range(5, 1)); l++) begin
                for (int k = 0; k < int'($urandom_range(8, 0)); k++) push(8'($urandom));
                for (int p = 0; p < int'($urandom_range(8, 1)); p++)
                    step(1'b0, 1'b0, 1'b0, 1'b1);
                step(1'b0, 1'b0, 1'b1, 1'b0);
                for (int g = 0; g < int'($urandom_range(2, 0)); g++)
                    step(1'b0, 1'b0, 1'b0, 1'b0);
            end
        end

        // Long underflow run: counter must saturate
        step(1'b1, 1'b0, 1'b0, 1'b0);
        clear_fifo();
        vs_pulse();
        for (int i = 0; i < 65540; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("sat_cnt", underflow_cnt, 16'hFFFF);
        chk("sat_flag", underflow, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
